// File: rtl/stream_demux_pkg.sv
// Shared definitions for the 1-to-4 sample stream demultiplexer:
// routing-mode encodings, channel index type and a one-hot helper.
package stream_demux_pkg;

    localparam logic [2:0] SEL_CH1   = 3'b000;
    localparam logic [2:0] SEL_CH2   = 3'b001;
    localparam logic [2:0] SEL_CH3   = 3'b010;
    localparam logic [2:0] SEL_CH4   = 3'b011;
    localparam logic [2:0] SEL_RR    = 3'b100;
    localparam logic [2:0] SEL_BCAST = 3'b101;
    localparam logic [2:0] SEL_DISC  = 3'b110;

    typedef logic [1:0] ch_idx_t;

    // One-hot channel mask for a channel index (bit0 = CH1)
    function automatic logic [3:0] ch_onehot(input ch_idx_t idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/demux_ch_slot.sv
// One-entry output register for a single demux channel with
// valid/ready handshake. A load in the same cycle as a drain keeps the
// slot valid with the new sample.
module demux_ch_slot #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             free
);

    // Slot can take a sample when empty or being drained this cycle
    assign free = ~valid | ready;

    // Holding register: load has priority over drain; data holds after drain
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/stream_demux1_4.sv
// Registered 1-to-4 sample stream demultiplexer.
// Modes: fixed channel, round-robin de-interleave (with in_sync realignment
// and sticky sync error), broadcast, and discard.
// Optional macro DEMUX_DROP_CNT_EN adds a saturating drop_cnt output that
// counts samples consumed in discard mode.
module stream_demux1_4
    import stream_demux_pkg::*;
#(
    parameter int INPUT_WIDTH  = 12,
    parameter int OUTPUT_WIDTH = 12
) (
    input  logic                    clk_in,
    input  logic                    RST_n,
    input  logic [2:0]              Sel,
    input  logic [INPUT_WIDTH-1:0]  in_data,
    input  logic                    in_valid,
    input  logic                    in_sync,
    output logic                    in_ready,
    output logic [OUTPUT_WIDTH-1:0] CH_OUT1,
    output logic [OUTPUT_WIDTH-1:0] CH_OUT2,
    output logic [OUTPUT_WIDTH-1:0] CH_OUT3,
    output logic [OUTPUT_WIDTH-1:0] CH_OUT4,
    output logic [3:0]              ch_valid,
    input  logic [3:0]              ch_ready,
`ifdef DEMUX_DROP_CNT_EN
    output logic [15:0]             drop_cnt,
`endif
    output logic                    sync_err
);

    if (OUTPUT_WIDTH < INPUT_WIDTH) begin : g_width_check
        $error("stream_demux1_4: OUTPUT_WIDTH must be >= INPUT_WIDTH");
    end

    logic [2:0]              sel_q;
    ch_idx_t                 rr_idx;
    ch_idx_t                 rr_idx_next;
    logic                    sync_err_next;
    ch_idx_t                 target;
    logic                    sel_change;
    logic                    mode_ready;
    logic                    is_rr;
    logic                    is_bcast;
    logic                    is_disc;
    logic                    accept;
    logic [3:0]              slot_free;
    logic [3:0]              load_mask;
    logic [OUTPUT_WIDTH-1:0] wide_data;
    logic [OUTPUT_WIDTH-1:0] ch_data [4];

    // Left-justify the input sample, zero-filling the LSBs
    always_comb begin
        wide_data = '0;
        wide_data[OUTPUT_WIDTH-1 -: INPUT_WIDTH] = in_data;
    end

    // Decode the routing mode into a target channel and mode-level ready
    always_comb begin
        sel_change = (Sel != sel_q);
        target     = Sel[1:0];
        mode_ready = 1'b0;
        is_rr      = 1'b0;
        is_bcast   = 1'b0;
        is_disc    = 1'b0;
        case (Sel)
            SEL_CH1, SEL_CH2, SEL_CH3, SEL_CH4: begin
                target     = Sel[1:0];
                mode_ready = slot_free[target];
            end
            SEL_RR: begin
                is_rr = 1'b1;
                // A mode change or sync pulse realigns the stream to CH1
                if (in_sync || sel_change) begin
                    target = 2'd0;
                end else begin
                    target = rr_idx;
                end
                mode_ready = slot_free[target];
            end
            SEL_BCAST: begin
                is_bcast   = 1'b1;
                mode_ready = &slot_free;
            end
            default: begin
                is_disc    = 1'b1;
                mode_ready = 1'b1;
            end
        endcase
    end

    // Handshake, slot loads and next round-robin / sync-error state
    always_comb begin
        in_ready = RST_n & mode_ready;
        accept   = in_valid & in_ready;
        if (!accept) begin
            load_mask = 4'b0000;
        end else if (is_bcast) begin
            load_mask = 4'b1111;
        end else if (is_disc) begin
            load_mask = 4'b0000;
        end else begin
            load_mask = ch_onehot(target);
        end

        if (sel_change) begin
            rr_idx_next = accept ? 2'd1 : 2'd0;
        end else if (is_rr && accept) begin
            rr_idx_next = target + 2'd1;
        end else begin
            rr_idx_next = rr_idx;
        end

        // Sync on a sample that was not due for CH1 flags misalignment
        if (is_rr && accept && in_sync && !sel_change && (rr_idx != 2'd0)) begin
            sync_err_next = 1'b1;
        end else begin
            sync_err_next = sync_err;
        end
    end

    // Mode history, round-robin pointer and sticky sync error
    always_ff @(posedge clk_in) begin
        if (!RST_n) begin
            sel_q    <= SEL_CH1;
            rr_idx   <= 2'd0;
            sync_err <= 1'b0;
        end else begin
            sel_q    <= Sel;
            rr_idx   <= rr_idx_next;
            sync_err <= sync_err_next;
        end
    end

`ifdef DEMUX_DROP_CNT_EN
    // Saturating count of samples consumed while discarding
    always_ff @(posedge clk_in) begin
        if (!RST_n) begin
            drop_cnt <= 16'h0000;
        end else if (accept && is_disc && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'h0001;
        end
    end
`endif

    for (genvar i = 0; i < 4; i++) begin : g_slot
        demux_ch_slot #(
            .WIDTH (OUTPUT_WIDTH)
        ) u_slot (
            .clk       (clk_in),
            .rst_n     (RST_n),
            .load      (load_mask[i]),
            .load_data (wide_data),
            .ready     (ch_ready[i]),
            .valid     (ch_valid[i]),
            .data      (ch_data[i]),
            .free      (slot_free[i])
        );
    end

    assign CH_OUT1 = ch_data[0];
    assign CH_OUT2 = ch_data[1];
    assign CH_OUT3 = ch_data[2];
    assign CH_OUT4 = ch_data[3];

endmodule

// File: doc/stream_demux1_4.md
Name: stream_demux1_4

Overview:
- Registered 1-to-4 demultiplexer for sample streams; the distribution counterpart of the 4:1 channel mux.
- Routes one input sample stream to four channel outputs. Routing is fixed-channel, round-robin de-interleave, broadcast, or discard.
- Sits between a time-multiplexed ADC/DDS sample source and per-channel processing chains.
- Uses valid/ready flow control on every port.

Parameters:
- INPUT_WIDTH, 12, input sample width.
- OUTPUT_WIDTH, 12, channel output width; must be >= INPUT_WIDTH (elaboration error otherwise).

Ports:
- clk_in  input  1  system clock; all logic on rising edge.
- RST_n  input  1  synchronous, active-low reset.
- Sel  input  3  routing mode: 000..011 = CH1..CH4; 100 = round-robin; 101 = broadcast; 110/111 = discard.
- in_data  input  INPUT_WIDTH  input sample.
- in_valid  input  1  input sample valid.
- in_sync  input  1  qualifies in_data as a CH1 sample (round-robin only).
- in_ready  output  1  block can accept the input this cycle.
- CH_OUT1..CH_OUT4  output  OUTPUT_WIDTH each  channel data.
- ch_valid  output  4  per-channel valid; bit0 = CH1.
- ch_ready  input  4  per-channel downstream ready.
- sync_err  output  1  sticky round-robin sync error.

Behaviour:
- Reset: when RST_n = 0 at a clock edge, the following clear: ch_valid = 0, CH_OUT1..4 = 0, rr_idx = 0, sel_q = 000, sync_err = 0. in_ready is combinational and is forced to 0 while RST_n = 0.
- Width rule: output = in_data in the MSBs, LSBs zero-filled (in_data << (OUTPUT_WIDTH-INPUT_WIDTH)).
- Channel slot: each channel has a one-entry register.
  - slot_free[i] = ~ch_valid[i] | ch_ready[i].
  - Downstream handshake: ch_valid & ch_ready.
  - A slot drained and written in the same cycle stays valid with the new data.
- Target selection (combinational, each cycle):
  - Fixed modes: target = Sel[1:0].
  - Round-robin: target = (in_sync ? 0 : rr_idx).
  - Broadcast: all four channels.
- in_ready:
  - Fixed / round-robin: slot_free[target].
  - Broadcast: AND of all four slot_free.
  - Discard: 1.
- Accept = in_valid & in_ready. Latency from accept to ch_valid is 1 cycle. No combinational path from in_data to CH_OUTx.
- Round-robin counter:
  - On accept, rr_idx <= target+1, wrapping 3 -> 0.
  - in_sync with rr_idx != 0 on accept sets sync_err; it stays set until reset.
  - in_sync is ignored in all other modes.
- Sel change: sel_q registers Sel every cycle. If Sel != sel_q, that cycle's round-robin target is forced to 0 and rr_idx <= (accept ? 1 : 0). Samples already in slots are unaffected.
- Back-pressure: a stalled channel blocks only the inputs targeting it. In round-robin, one stalled channel stalls the whole stream; this is intentional to keep ordering.
- Discard mode: samples are consumed and no slot changes.
- Reset mid-operation discards held samples; no ch_valid is asserted in the cycle after reset.

Optional Feature:
- DEMUX_DROP_CNT_EN defined: adds output drop_cnt [15:0].
  - Increments on each accept in discard mode and saturates at 16'hFFFF.
  - Cleared by reset.
- Macro undefined: no port and no counter logic.

Decomposition:
- Package stream_demux_pkg:
  - Localparams SEL_CH1..SEL_CH4, SEL_RR, SEL_BCAST, SEL_DISC (3-bit).
  - Typedef ch_idx_t (2-bit).
- One sub-module, demux_ch_slot: a one-entry output register with load/valid/ready. Instantiated 4 times via generate.

Test Plan:
- Fixed route: Sel=010, INPUT_WIDTH=12, OUTPUT_WIDTH=16, in_data=12'hABC, ch_ready=4'hF → next cycle ch_valid=4'b0100, CH_OUT3=16'hABC0; other outputs unchanged.
- Round-robin: Sel=100, samples 1..8 back-to-back, in_sync on samples 1 and 5 → CH1 gets 1,5; CH2 gets 2,6; CH3 gets 3,7; CH4 gets 4,8; sync_err=0.
- Sync error: Sel=100, in_sync on the 3rd sample → that sample lands on CH1, sync_err=1 and stays 1; the next sample goes to CH2.
- Back-pressure: Sel=001, ch_ready[1]=0, two samples 0x111, 0x222 → first held on CH2, in_ready=0. ch_ready[1] goes to 1 → 0x111 taken, 0x222 loaded the same cycle, no loss.
- Broadcast with one stall: Sel=101, ch_ready=4'b1011 while CH3 is full → in_ready=0. Release ch_ready[2] → sample appears on all four channels in the same cycle.
- Reset/discard: Sel=110, 5 samples accepted → drop_cnt=5 (with macro), all ch_valid=0. Assert RST_n=0 for 1 cycle → drop_cnt=0, sync_err=0, ch_valid=0.
